// File: rtl/latch_wr_arbiter_pkg.sv
// Shared types and defaults for the latch-bank write arbiter.
// Holds the write-sequencer state encoding and an index-width helper.
package latch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_WIDTH    = 4;
    localparam int DEF_OPEN_CYC = 1;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/latch_wr_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping from NREQ-1 back to 0.
module rr_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_valid
);

    logic w_found;
    int   w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_k = (int'(i_ptr) + i) % NREQ;
            if (!w_found && i_req[w_k]) begin
                w_found      = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx        = IDW'(w_k);
            end
        end
    end

    assign o_valid = w_found;

endmodule

// File: rtl/latch_wr_arbiter.sv
// Shares one transparent-latch bank between NREQ requesters; each write runs
// setup -> gate open (OPEN_CYC cycles) -> hold, with every output registered.
module latch_wr_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter  int NREQ     = DEF_NREQ,
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int OPEN_CYC = DEF_OPEN_CYC,
    localparam int IDW      = idx_width(NREQ),
    localparam int CW       = $clog2(OPEN_CYC + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_wdata,
    output logic [NREQ-1:0]       o_ack,
    output logic                  o_busy,
    output logic [IDW-1:0]        o_gnt_id,
    output logic                  o_lat_ena,
    output logic [WIDTH-1:0]      o_lat_d
);

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [IDW-1:0]    r_ptr, w_ptr_nxt;
    logic [IDW-1:0]    r_gnt_id, w_gnt_id_nxt;
    logic [NREQ-1:0]   r_gnt_oh, w_gnt_oh_nxt;
    logic [NREQ-1:0]   r_ack, w_ack_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_lat_ena, w_lat_ena_nxt;
    logic [WIDTH-1:0]  r_lat_d, w_lat_d_nxt;

    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_idx;
    logic              w_valid;
    logic [WIDTH-1:0]  w_wdata_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_wdata_arr[g] = i_wdata[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    // Next-state and next-register values; lat_ena is computed here but lives in its own flop.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ptr_nxt     = r_ptr;
        w_gnt_id_nxt  = r_gnt_id;
        w_gnt_oh_nxt  = r_gnt_oh;
        w_ack_nxt     = '0;
        w_lat_ena_nxt = r_lat_ena;
        w_lat_d_nxt   = r_lat_d;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt  = SETUP;
                    w_gnt_id_nxt = w_idx;
                    w_gnt_oh_nxt = w_grant;
                    w_lat_d_nxt  = w_wdata_arr[w_idx];
                end
            end
            SETUP: begin
                w_state_nxt   = OPEN;
                w_lat_ena_nxt = 1'b1;
                w_cnt_nxt     = CW'(OPEN_CYC - 1);
            end
            OPEN: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = HOLD;
                    w_lat_ena_nxt = 1'b0;
                    w_ack_nxt     = r_gnt_oh;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            HOLD: begin
                w_state_nxt   = IDLE;
                w_lat_ena_nxt = 1'b0;
                w_ptr_nxt     = (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + IDW'(1);
            end
            default: begin
                w_state_nxt   = IDLE;
                w_lat_ena_nxt = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_gnt_id  <= '0;
            r_gnt_oh  <= '0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
            r_lat_ena <= 1'b0;
            r_lat_d   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_gnt_oh  <= w_gnt_oh_nxt;
            r_ack     <= w_ack_nxt;
            r_busy    <= w_busy_nxt;
            r_lat_ena <= w_lat_ena_nxt;
            r_lat_d   <= w_lat_d_nxt;
        end
    end

    assign o_ack     = r_ack;
    assign o_busy    = r_busy;
    assign o_gnt_id  = r_gnt_id;
    assign o_lat_ena = r_lat_ena;
    assign o_lat_d   = r_lat_d;

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// Bench for latch_wr_arbiter: two instances (gate open 1 and 3 cycles) checked
// every cycle against a phase-count model, plus directed literal expectations.
module tb_latch_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req   = '0;
    logic [15:0] wdata = '0;

    logic [3:0] ackA, ackB, dA, dB, prevDA, prevDB;
    logic [1:0] gntA, gntB;
    logic       busyA, busyB, enaA, enaB;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    int         mPhase [2] = '{0, 0};
    int         mGnt   [2] = '{0, 0};
    int         mPtr   [2] = '{0, 0};
    logic [3:0] mD     [2] = '{4'h0, 4'h0};
    int         mOc    [2] = '{1, 3};

    always #5 clk = ~clk;

    latch_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPEN_CYC(1)) uA (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wdata(wdata),
        .o_ack(ackA), .o_busy(busyA), .o_gnt_id(gntA), .o_lat_ena(enaA), .o_lat_d(dA)
    );

    latch_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPEN_CYC(3)) uB (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wdata(wdata),
        .o_ack(ackB), .o_busy(busyB), .o_gnt_id(gntB), .o_lat_ena(enaB), .o_lat_d(dB)
    );

    function automatic int pickNext(input logic [3:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return 0;
    endfunction

    // A write is a phase count from its grant: 1 = setup, gate open for OPEN_CYC phases, then ack.
    always @(posedge clk or negedge rst_n) begin
        for (int n = 0; n < 2; n++) begin
            if (!rst_n) begin
                mPhase[n] = 0;
                mGnt[n]   = 0;
                mPtr[n]   = 0;
                mD[n]     = '0;
            end else if (mPhase[n] == 0) begin
                if (req != 4'b0000) begin
                    mGnt[n]   = pickNext(req, mPtr[n]);
                    mD[n]     = wdata[mGnt[n]*WIDTH +: WIDTH];
                    mPhase[n] = 1;
                end
            end else begin
                mPhase[n] = mPhase[n] + 1;
                if (mPhase[n] == mOc[n] + 3) begin
                    mPhase[n] = 0;
                    mPtr[n]   = (mGnt[n] + 1) % NREQ;
                end
            end
        end
    end

    task automatic checkVal(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic checkOutput(input int n, input logic [3:0] ack, input logic busy,
                               input logic [1:0] gnt, input logic ena,
                               input logic [3:0] d, input logic [3:0] prevD);
        int expAck;
        int expEna;
        expAck = (mPhase[n] == mOc[n] + 2) ? (1 << mGnt[n]) : 0;
        expEna = (mPhase[n] >= 2 && mPhase[n] <= mOc[n] + 1) ? 1 : 0;
        checkVal($sformatf("inst%0d_ack", n),    int'(ack),  expAck);
        checkVal($sformatf("inst%0d_busy", n),   int'(busy), (mPhase[n] != 0) ? 1 : 0);
        checkVal($sformatf("inst%0d_gnt", n),    int'(gnt),  mGnt[n]);
        checkVal($sformatf("inst%0d_ena", n),    int'(ena),  expEna);
        checkVal($sformatf("inst%0d_latd", n),   int'(d),    int'(mD[n]));
        checkVal($sformatf("inst%0d_onehot", n), int'($onehot0(ack)), 1);
        if (ena) checkVal($sformatf("inst%0d_dstable", n), int'(d), int'(prevD));
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput(0, ackA, busyA, gntA, enaA, dA, prevDA);
            checkOutput(1, ackB, busyB, gntB, enaB, dB, prevDB);
        end
        prevDA = dA;
        prevDB = dB;
    end

    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] w);
        req   = r;
        wdata = w;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        // Test 1: single request, reset values and one-gate write timing
        doReset();
        checking = 1'b1;
        checkVal("rst_ack",  int'(ackA),  0);
        checkVal("rst_busy", int'(busyA), 0);
        checkVal("rst_gnt",  int'(gntA),  0);
        checkVal("rst_ena",  int'(enaA),  0);
        checkVal("rst_latd", int'(dA),    0);
        applyStimulus(4'b0100, 16'h0A00);
        tick();
        checkVal("t1_latd_c1", int'(dA), 4'hA);
        checkVal("t1_ena_c1",  int'(enaA), 0);
        checkVal("t1_busy_c1", int'(busyA), 1);
        tick();
        checkVal("t1_ena_c2", int'(enaA), 1);
        tick();
        checkVal("t1_ack_c3", int'(ackA), 4'b0100);
        checkVal("t1_ena_c3", int'(enaA), 0);
        applyStimulus(4'b0000, 16'h0A00);
        tick();
        checkVal("t1_busy_c4", int'(busyA), 0);
        checkVal("t1_ack_c4",  int'(ackA), 0);

        // Test 2: all four requesting, served 0..3 every four cycles
        doReset();
        applyStimulus(4'b1111, 16'h4321);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k % 4 == 3) begin
                checkVal("t2_ack",  int'(ackA), 1 << ((k - 3) / 4));
                checkVal("t2_latd", int'(dA),   (k - 3) / 4 + 1);
            end
        end

        // Test 3: requesters 0 and 2 alternate
        doReset();
        applyStimulus(4'b0101, 16'h0C05);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k % 4 == 3) begin
                checkVal("t3_ack", int'(ackA), (((k - 3) / 4) % 2 == 0) ? 4'b0001 : 4'b0100);
                checkVal("t3_gnt", int'(gntA), (((k - 3) / 4) % 2 == 0) ? 0 : 2);
            end
        end

        // Test 4: three-cycle gate on instance B
        doReset();
        applyStimulus(4'b0001, 16'h0009);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkVal("t4_ena", int'(enaB), (k >= 2 && k <= 4) ? 1 : 0);
            checkVal("t4_ack", int'(ackB), (k == 5) ? 1 : 0);
            if (k <= 5) checkVal("t4_latd", int'(dB), 9);
            if (k == 5) applyStimulus(4'b0000, 16'h0009);
        end

        // Test 5: reset during the gate pulse
        doReset();
        applyStimulus(4'b0001, 16'h0065);
        repeat (3) tick();
        checkVal("t5_ack0", int'(ackA), 4'b0001);
        applyStimulus(4'b0011, 16'h0065);
        tick();
        checkVal("t5_busy_gap", int'(busyA), 0);
        tick();
        checkVal("t5_gnt1", int'(gntA), 1);
        tick();
        checkVal("t5_ena_open", int'(enaA), 1);
        #2 rst_n = 1'b0;
        #1;
        checkVal("t5_async_enaA", int'(enaA), 0);
        checkVal("t5_async_enaB", int'(enaB), 0);
        checkVal("t5_async_ack",  int'(ackA), 0);
        checkVal("t5_async_busy", int'(busyA), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        checkVal("t5_regrant_gnt",  int'(gntA), 0);
        checkVal("t5_regrant_busy", int'(busyA), 1);
        repeat (2) tick();
        checkVal("t5_regrant_ack", int'(ackA), 4'b0001);
        applyStimulus(4'b0000, 16'h0065);

        // Test 6: requester drops req and changes data during setup
        doReset();
        applyStimulus(4'b0010, 16'h0070);
        tick();
        checkVal("t6_latd_c1", int'(dA), 4'h7);
        applyStimulus(4'b0000, 16'h00F0);
        tick();
        checkVal("t6_ena_c2",  int'(enaA), 1);
        checkVal("t6_latd_c2", int'(dA), 4'h7);
        tick();
        checkVal("t6_ack_c3",  int'(ackA), 4'b0010);
        checkVal("t6_latd_c3", int'(dA), 4'h7);
        tick();
        checkVal("t6_busy_c4", int'(busyA), 0);

        repeat (6) tick();
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
